// File: rtl/vedic_seq_mul_8bit.sv
`default_nettype none
// ============================================================================
// Module   : vedic_seq_mul_8bit (with combinational 4x4 Vedic core `multi`)
// Brief    : 8x8 unsigned multiplier, one nibble pair per cycle, valid/ready.
// Revision : 1.0
// ============================================================================

module multi (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // Urdhva-Tiryagbhyam 2x2 building block: vertical and crosswise products.
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic cross_c;
        logic hi;
        vedic2[0] = x[0] & y[0];
        vedic2[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        cross_c   = (x[1] & y[0]) & (x[0] & y[1]);
        hi        = x[1] & y[1];
        vedic2[2] = hi ^ cross_c;
        vedic2[3] = hi & cross_c;
    endfunction

    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic [5:0] mid;

    assign q0  = vedic2(a[1:0], b[1:0]);
    assign q1  = vedic2(a[3:2], b[1:0]);
    assign q2  = vedic2(a[1:0], b[3:2]);
    assign q3  = vedic2(a[3:2], b[3:2]);
    assign mid = {2'b00, q1} + {2'b00, q2};
    assign p   = {4'b0000, q0} + {mid, 2'b00} + {q3, 4'b0000};
endmodule

module vedic_seq_mul_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [7:0]  ra_q, ra_d;
    logic [7:0]  rb_q, rb_d;
    logic [15:0] acc_q, acc_d;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;

    // step[0] picks the high nibble of ra, step[1] the high nibble of rb.
    always_comb begin
        nib_a = step_q[0] ? ra_q[7:4] : ra_q[3:0];
        nib_b = step_q[1] ? rb_q[7:4] : rb_q[3:0];
        case (step_q)
            2'd0:    pp_shifted = {8'h00, pp};
            2'd3:    pp_shifted = {pp, 8'h00};
            default: pp_shifted = {4'h0, pp, 4'h0};
        endcase
    end

    multi u_multi (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = b;
                    acc_d   = 16'h0000;
                    step_d  = 2'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            ra_q    <= 8'h00;
            rb_q    <= 8'h00;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
        end
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign p         = acc_q;
endmodule

`default_nettype wire

// File: doc/vedic_seq_mul_8bit.md
# vedic_seq_mul_8bit

Sequential 8x8 unsigned multiplier built around a single instance of the team's combinational 4-bit Vedic multiplier (`multi`). It splits each operand into nibbles, feeds one nibble pair to `multi` per cycle, and accumulates the shifted 8-bit partial products into a 16-bit result. A valid/ready handshake sits on both the operand side and the result side. It is the stage that drives `multi` and consumes its product.

## Interface

Parameters:
- None. Operand width is fixed at 8 bits, because the 4-bit core is fixed.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair a/b is presented.
- in_ready  output  1  block can accept an operand pair.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  downstream accepts p.
- p  output  16  product a*b, unsigned.
- busy  output  1  high in MUL or DONE.

## Operation

States and transitions:
- IDLE
  - in_ready=1.
  - On in_valid&in_ready: latch a→ra and b→rb, clear acc, set step=0, go to MUL.
- MUL
  - 2-bit step counter, values 0..3.
  - `multi` inputs are selected from the latched operands:
    - step0: ra[3:0]×rb[3:0], shift 0.
    - step1: ra[7:4]×rb[3:0], shift 4.
    - step2: ra[3:0]×rb[7:4], shift 4.
    - step3: ra[7:4]×rb[7:4], shift 8.
  - Each cycle: acc ← acc + ({8'b0,pp} << shift). pp is the 8-bit `multi` output. The add is 16-bit and never overflows; the maximum is 0xFE01.
  - At step3: go to DONE; step wraps to 0.
- DONE
  - out_valid=1; p=acc, held stable.
  - On out_valid&out_ready: go to IDLE.
- in_ready is asserted only in IDLE. There is no overlap of operations.
- in_valid outside IDLE is ignored. Changes on a/b after acceptance have no effect.
- p is driven from acc in all states. It is only meaningful while out_valid=1.
- Operations are independent. acc is cleared on every acceptance, so no accumulation carries over between operations.

## Timing

Reset values, taking effect at the rising edge with rst_n=0:
- State=IDLE.
- acc=0, p=0x0000.
- step=0, ra=rb=0.
- out_valid=0, busy=0.
- in_ready=0 while rst_n=0, and 1 from the first cycle after release.

Cycle-level behaviour:
- Latency: the acceptance edge is E0. The partial products accumulate on edges E1..E4. out_valid rises after E4. The result is therefore valid 4 cycles after acceptance.
- Minimum initiation interval is 6 cycles, when out_ready is held high:
  - 1 accept cycle.
  - 4 MUL cycles.
  - 1 DONE cycle.
  - Return to IDLE, where in_ready=1.
- Backpressure: DONE holds indefinitely while out_ready=0. p and out_valid stay stable.
- out_ready is a don't-care outside DONE.

Boundary cases:
- Reset mid-operation, in MUL or DONE: the operation is aborted with no out_valid pulse. The block is back in IDLE with acc=0 on the next cycle.
- in_valid and reset in the same cycle: reset wins and the operand is not accepted.
- in_valid held high across completion: the next pair is accepted only in IDLE, one cycle after the DONE handshake.
- All outputs are registered, or decoded from registered state, except in_ready. in_ready is decoded from state and is never asserted during reset.

## Test plan

- Reset, then a=0xFF, b=0xFF with in_valid for one cycle → out_valid rises exactly 4 cycles after acceptance, with p=0xFE01. With out_ready=1, in_ready returns one cycle later.
- a=0x12, b=0x34 → p=0x03A8. Then a=0xA5, b=0x5A → p=0x3A02. Then a=0x00, b=0xC7 → p=0x0000. Check that each result is independent (acc cleared between operations).
- Backpressure: complete 0x0F×0xF0 (p=0x0E10) with out_ready=0 for 10 cycles → out_valid stays 1, p stays 0x0E10, in_ready stays 0. Raise out_ready → a one-cycle handshake, then IDLE.
- Operand isolation: accept a=0x80, b=0x02, then change a/b to 0xFF and hold in_valid=1 during MUL → p=0x0100. The second pair is accepted only after the DONE handshake.
- Reset mid-op: assert rst_n=0 during step2 → no out_valid pulse, p=0x0000, busy=0. The next operation, 0x10×0x10, gives p=0x0100 with normal latency.
- Random regression: 2000 random a/b pairs with random out_ready stalls, compared against a golden a*b model → all match, and the latency is always 4 cycles.
